// File: rtl/hd_program_loader_pkg.sv
// Shared definitions for the HD program loader: FSM state encodings,
// default geometry and header field positions.
// Optional feature macro: HD_LOAD_CHECKSUM_EN (adds the checksum states).
package hd_program_loader_pkg;

  localparam int unsigned BLOCK_SIZE_DEF = 200;   // words per block, header included
  localparam int unsigned HD_DEPTH_DEF   = 4000;  // HD size in words
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned IMEM_AW_DEF    = 10;

  // Header word layout: program length in words.
  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_REQ   = 3'd1,
    ST_HDR_WAIT  = 3'd2,
    ST_DATA_REQ  = 3'd3,
    ST_DATA_WAIT = 3'd4,
`ifdef HD_LOAD_CHECKSUM_EN
    ST_CHK_REQ   = 3'd5,
    ST_CHK_WAIT  = 3'd6,
`endif
    ST_FIN       = 3'd7
  } state_t;

endpackage

// File: rtl/hd_block_addr.sv
// Converts an HD block number into the block's first word address and
// flags block numbers whose base lies beyond the end of the HD.
module hd_block_addr #(
  parameter int unsigned BLOCK_SIZE = 200,
  parameter int unsigned HD_DEPTH   = 4000
) (
  input  logic [7:0]  block_num,
  output logic [31:0] base,
  output logic        out_of_range
);

  assign base         = 32'(block_num) * 32'(BLOCK_SIZE);
  assign out_of_range = (base >= 32'(HD_DEPTH));

endmodule

// File: rtl/hd_program_loader.sv
// Copies one program from an HD block into instruction memory.
// Reads the block header (length), then streams that many words into
// consecutive imem addresses starting at the captured destination base.
// Optional feature macro: HD_LOAD_CHECKSUM_EN -- XOR of the data words is
// compared with the word following the program; mismatch reports err_o.
module hd_program_loader
  import hd_program_loader_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int unsigned HD_DEPTH   = HD_DEPTH_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned IMEM_AW    = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [7:0]         block_num_i,
  input  logic [IMEM_AW-1:0] dst_base_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [15:0]        words_o,
  output logic               hd_req_o,
  output logic [31:0]        hd_addr_o,
  input  logic [DATA_W-1:0]  hd_rdata_i,
  input  logic               hd_rvalid_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [DATA_W-1:0]  imem_wdata_o
);

  // The checksum word occupies one slot of the block, shortening the program.
`ifdef HD_LOAD_CHECKSUM_EN
  localparam logic [15:0] LEN_MAX = 16'(BLOCK_SIZE - 2);
`else
  localparam logic [15:0] LEN_MAX = 16'(BLOCK_SIZE - 1);
`endif

  state_t              state_q, state_d;
  logic [31:0]         blk_base;
  logic                blk_oor;
  logic [31:0]         base_q;
  logic [IMEM_AW-1:0]  dst_q;
  logic [15:0]         len_q;
  logic [15:0]         rd_idx_q;
  logic                err_q;
  logic [15:0]         words_q;
  logic                imem_we_q;
  logic [IMEM_AW-1:0]  imem_addr_q;
  logic [DATA_W-1:0]   imem_wdata_q;
  logic [15:0]         hdr_len;
  logic                hdr_bad;
  logic                more_words;
  logic [31:0]         data_addr;
`ifdef HD_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0]   chk_acc_q;
`endif

  hd_block_addr #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .HD_DEPTH   (HD_DEPTH)
  ) u_block_addr (
    .block_num    (block_num_i),
    .base         (blk_base),
    .out_of_range (blk_oor)
  );

  assign hdr_len    = hd_rdata_i[LEN_MSB:LEN_LSB];
  assign hdr_bad    = (hdr_len > LEN_MAX) || ((base_q + 32'(hdr_len)) >= 32'(HD_DEPTH));
  assign more_words = (rd_idx_q < len_q);
  // Once all data is read rd_idx_q == len_q, so this also addresses the checksum word.
  assign data_addr  = base_q + 32'd1 + 32'(rd_idx_q);

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_FIN);
  assign err_o        = done_o & err_q;
  assign words_o      = words_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and HD request decode; one read outstanding at a time.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    state_d   = state_q;
    hd_req_o  = 1'b0;
    hd_addr_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = blk_oor ? ST_FIN : ST_HDR_REQ;
      end
      ST_HDR_REQ: begin
        hd_req_o  = 1'b1;
        hd_addr_o = base_q;
        state_d   = ST_HDR_WAIT;
      end
      ST_HDR_WAIT: begin
        hd_addr_o = base_q;
        if (hd_rvalid_i) state_d = ((hdr_len == 16'd0) || hdr_bad) ? ST_FIN : ST_DATA_REQ;
      end
      ST_DATA_REQ: begin
        hd_addr_o = data_addr;
        if (more_words) begin
          hd_req_o = 1'b1;
          state_d  = ST_DATA_WAIT;
        end else begin
`ifdef HD_LOAD_CHECKSUM_EN
          state_d = ST_CHK_REQ;
`else
          state_d = ST_FIN;
`endif
        end
      end
      ST_DATA_WAIT: begin
        hd_addr_o = data_addr;
        if (hd_rvalid_i) state_d = ST_DATA_REQ;
      end
`ifdef HD_LOAD_CHECKSUM_EN
      ST_CHK_REQ: begin
        hd_req_o  = 1'b1;
        hd_addr_o = data_addr;
        state_d   = ST_CHK_WAIT;
      end
      ST_CHK_WAIT: begin
        hd_addr_o = data_addr;
        if (hd_rvalid_i) state_d = ST_FIN;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture the command, header length, and register each data word for its imem write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q       <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      rd_idx_q     <= '0;
      err_q        <= 1'b0;
      words_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef HD_LOAD_CHECKSUM_EN
      chk_acc_q    <= '0;
`endif
    end else begin
      // NOTE: state updates here are non-blocking so every register sees the pre-edge values.
      imem_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            base_q   <= blk_base;
            dst_q    <= dst_base_i;
            err_q    <= blk_oor;
            words_q  <= '0;
            rd_idx_q <= '0;
            len_q    <= '0;
`ifdef HD_LOAD_CHECKSUM_EN
            chk_acc_q <= '0;
`endif
          end
        end
        ST_HDR_WAIT: begin
          if (hd_rvalid_i) begin
            len_q <= hdr_len;
            err_q <= hdr_bad;
          end
        end
        ST_DATA_WAIT: begin
          if (hd_rvalid_i) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= dst_q + rd_idx_q[IMEM_AW-1:0];
            imem_wdata_q <= hd_rdata_i;
            words_q      <= rd_idx_q + 16'd1;
            rd_idx_q     <= rd_idx_q + 16'd1;
`ifdef HD_LOAD_CHECKSUM_EN
            chk_acc_q    <= chk_acc_q ^ hd_rdata_i;
`endif
          end
        end
`ifdef HD_LOAD_CHECKSUM_EN
        ST_CHK_WAIT: begin
          if (hd_rvalid_i) err_q <= (hd_rdata_i != chk_acc_q);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_program_loader.sv
// Directed self-checking bench for hd_program_loader with a 1-cycle
// latency HD model and a behavioural imem.
module tb_hd_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  block_num_i;
  logic [9:0]  dst_base_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] words_o;
  logic        hd_req_o;
  logic [31:0] hd_addr_o;
  logic [31:0] hd_rdata_i;
  logic        hd_rvalid_i;
  logic        imem_we_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;

  localparam logic [31:0] WA = 32'hA5A5_0001;
  localparam logic [31:0] WB = 32'h5A5A_0002;
  localparam logic [31:0] WC = 32'h1234_0003;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic [31:0] hd_mem [0:3999];
  logic [31:0] imem   [0:1023];
  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int req_count = 0;
  int done_count = 0;
  int cyc = 0;
  int last_wr = 0;
  int last_gap = 0;

  hd_program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .block_num_i  (block_num_i),
    .dst_base_i   (dst_base_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .words_o      (words_o),
    .hd_req_o     (hd_req_o),
    .hd_addr_o    (hd_addr_o),
    .hd_rdata_i   (hd_rdata_i),
    .hd_rvalid_i  (hd_rvalid_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o)
  );

  always #5 clk = ~clk;

  // HD model: data returned one cycle after each request.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hd_rvalid_i <= 1'b0;
      hd_rdata_i  <= '0;
    end else begin
      hd_rvalid_i <= hd_req_o;
      hd_rdata_i  <= (hd_addr_o < 32'd4000) ? hd_mem[hd_addr_o] : 32'hBAD0_BAD0;
    end
  end

  // imem model plus write spacing bookkeeping.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (imem_we_o) begin
      imem[imem_addr_o] = imem_wdata_o;
      if (wr_count > 0) last_gap = cyc - last_wr;
      last_wr  = cyc;
      wr_count = wr_count + 1;
    end
  end

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (done_o)   done_count = done_count + 1;
    if (hd_req_o) req_count  = req_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one start and wait (bounded) for done_o; optionally pokes start while busy.
  task automatic do_load(input logic [7:0] blk, input logic [9:0] dst, input bit poke,
                         output int lat, output logic err, output logic [15:0] words,
                         output logic busy_at_done, output logic busy_after);
    @(negedge clk);
    block_num_i = blk;
    dst_base_i  = dst;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    if (poke) begin
      block_num_i = 8'd20;
      dst_base_i  = 10'h300;
      start_i     = 1'b1;
    end
    while (!done_o && lat < 500) begin
      @(negedge clk);
      lat++;
      if (lat == 3) start_i = 1'b0;
    end
    start_i = 1'b0;
    check("done_timeout", 32'(lat < 500), 32'd1);
    err          = err_o;
    words        = words_o;
    busy_at_done = busy_o;
    @(negedge clk);
    busy_after = busy_o;
  endtask

  int          lat;
  logic        err;
  logic [15:0] words;
  logic        bad, baf;
  int          d0, r0, w0, n;

  initial begin
    reset       = 1'b1;
    start_i     = 1'b0;
    block_num_i = '0;
    dst_base_i  = '0;
    for (int i = 0; i < 4000; i++) hd_mem[i] = 32'd0;
    for (int i = 0; i < 1024; i++) imem[i] = SENT;
    // Block 2 (base 400): len 3, A,B,C, then checksum word.
    hd_mem[400] = 32'd3;
    hd_mem[401] = WA;
    hd_mem[402] = WB;
    hd_mem[403] = WC;
    hd_mem[404] = WA ^ WB ^ WC;
    // Block 3 (base 600): len 2 for the destination wrap test.
    hd_mem[600] = 32'd2;
    hd_mem[601] = 32'h0000_1111;
    hd_mem[602] = 32'h0000_2222;
    hd_mem[603] = 32'h0000_3333;
    // Block 5 (base 1000): oversized header.
    hd_mem[1000] = 32'd250;

    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_o),    32'd0);
    check("rst_done",  32'(done_o),    32'd0);
    check("rst_err",   32'(err_o),     32'd0);
    check("rst_words", 32'(words_o),   32'd0);
    check("rst_req",   32'(hd_req_o),  32'd0);
    check("rst_we",    32'(imem_we_o), 32'd0);
    reset = 1'b0;

    // Normal load with a start poked while busy.
    d0 = done_count; w0 = wr_count;
    do_load(8'd2, 10'h010, 1'b1, lat, err, words, bad, baf);
    check("b2_err",       32'(err),   32'd0);
    check("b2_words",     32'(words), 32'd3);
    check("b2_busy_fin",  32'(bad),   32'd1);
    check("b2_busy_idle", 32'(baf),   32'd0);
    check("b2_imem10",    imem[10'h010], WA);
    check("b2_imem11",    imem[10'h011], WB);
    check("b2_imem12",    imem[10'h012], WC);
    check("b2_imem13",    imem[10'h013], SENT);
    check("b2_wr_count",  32'(wr_count - w0), 32'd3);
    check("b2_wr_gap",    32'(last_gap), 32'd2);
    repeat (6) @(negedge clk);
    check("b2_one_done",  32'(done_count - d0), 32'd1);

    // Empty program.
    w0 = wr_count;
    do_load(8'd0, 10'h020, 1'b0, lat, err, words, bad, baf);
    check("len0_latency", 32'(lat <= 4), 32'd1);
    check("len0_err",     32'(err),   32'd0);
    check("len0_words",   32'(words), 32'd0);
    check("len0_no_wr",   32'(wr_count - w0), 32'd0);

    // Block past end of HD: no HD access at all.
    r0 = req_count;
    do_load(8'd20, 10'h030, 1'b0, lat, err, words, bad, baf);
    check("oor_err",    32'(err), 32'd1);
    check("oor_no_req", 32'(req_count - r0), 32'd0);

    // Oversized header.
    w0 = wr_count;
    do_load(8'd5, 10'h030, 1'b0, lat, err, words, bad, baf);
    check("len250_err",   32'(err), 32'd1);
    check("len250_no_wr", 32'(wr_count - w0), 32'd0);

    // Destination wraps past the top of imem.
    do_load(8'd3, 10'h3FF, 1'b0, lat, err, words, bad, baf);
    check("wrap_err",   32'(err),   32'd0);
    check("wrap_words", 32'(words), 32'd2);
    check("wrap_3ff",   imem[10'h3FF], 32'h0000_1111);
    check("wrap_000",   imem[10'h000], 32'h0000_2222);

    // Reset after the second word, then a clean reload.
    w0 = wr_count;
    @(negedge clk);
    block_num_i = 8'd2; dst_base_i = 10'h040; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (wr_count < w0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_timeout", 32'(n < 200), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_busy",  32'(busy_o),    32'd0);
    check("rstmid_we",    32'(imem_we_o), 32'd0);
    check("rstmid_words", 32'(words_o),   32'd0);
    check("rstmid_req",   32'(hd_req_o),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_no_more_wr", 32'(wr_count - w0), 32'd2);
    check("rstmid_imem42",     imem[10'h042], SENT);
    do_load(8'd2, 10'h040, 1'b0, lat, err, words, bad, baf);
    check("reload_err",    32'(err),   32'd0);
    check("reload_words",  32'(words), 32'd3);
    check("reload_imem42", imem[10'h042], WC);

`ifdef HD_LOAD_CHECKSUM_EN
    // Block 7 (base 1400): words 5,3 with checksum 6 (good) then 7 (bad).
    hd_mem[1400] = 32'd2;
    hd_mem[1401] = 32'd5;
    hd_mem[1402] = 32'd3;
    hd_mem[1403] = 32'd6;
    do_load(8'd7, 10'h080, 1'b0, lat, err, words, bad, baf);
    check("chk_ok_err",   32'(err),   32'd0);
    check("chk_ok_words", 32'(words), 32'd2);
    hd_mem[1403] = 32'd7;
    do_load(8'd7, 10'h080, 1'b0, lat, err, words, bad, baf);
    check("chk_bad_err",   32'(err),   32'd1);
    check("chk_bad_words", 32'(words), 32'd2);
    check("chk_bad_imem",  imem[10'h081], 32'd3);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
